// File: rtl/hazard_ctrl_gen2_if.sv
// Bus between the five-stage datapath and the hazard controller.
// Register indices and stage controls flow in; forwarding, stall, flush and counter values flow out.
interface hazard_ctrl_gen2_if #(
  parameter int REG_WIDTH = 4,
  parameter int CNT_WIDTH = 16
);
  logic [REG_WIDTH-1:0] rsD;
  logic [REG_WIDTH-1:0] rtD;
  logic                 useRsD;
  logic                 useRtD;
  logic [REG_WIDTH-1:0] rsE;
  logic [REG_WIDTH-1:0] rtE;
  logic [REG_WIDTH-1:0] rtM;
  logic [REG_WIDTH-1:0] WriteRegE;
  logic [REG_WIDTH-1:0] WriteRegM;
  logic [REG_WIDTH-1:0] WriteRegW;
  logic                 RegWriteE;
  logic                 RegWriteM;
  logic                 RegWriteW;
  logic                 MemReadE;
  logic                 MemReadW;
  logic                 MemWriteM;
  logic                 branch_taken;
  logic                 jump;
  logic [1:0]           fwd_a;
  logic [1:0]           fwd_b;
  logic                 mem_fwd;
  logic                 pc_stall;
  logic                 if_id_stall;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 flush_ex_mem;
  logic                 busy;
  logic [CNT_WIDTH-1:0] stall_count;
  logic [CNT_WIDTH-1:0] flush_count;

  modport master (
    output rsD, rtD, useRsD, useRtD, rsE, rtE, rtM,
    output WriteRegE, WriteRegM, WriteRegW, RegWriteE, RegWriteM, RegWriteW,
    output MemReadE, MemReadW, MemWriteM, branch_taken, jump,
    input  fwd_a, fwd_b, mem_fwd, pc_stall, if_id_stall,
    input  flush_if_id, flush_id_ex, flush_ex_mem, busy, stall_count, flush_count
  );

  modport slave (
    input  rsD, rtD, useRsD, useRtD, rsE, rtE, rtM,
    input  WriteRegE, WriteRegM, WriteRegW, RegWriteE, RegWriteM, RegWriteW,
    input  MemReadE, MemReadW, MemWriteM, branch_taken, jump,
    output fwd_a, fwd_b, mem_fwd, pc_stall, if_id_stall,
    output flush_if_id, flush_id_ex, flush_ex_mem, busy, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl_gen2.sv
// Second-generation hazard controller: EX/MEM operand forwarding, load-use stalls and
// branch/jump flushes driven by a small IDLE/LDSTALL/BFLUSH FSM, plus saturating event counters.
module hazard_ctrl_gen2 #(
  parameter int REG_WIDTH         = 4,
  parameter int FLUSH_CYCLES      = 3,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int ZERO_REG_EN       = 1,
  parameter int CNT_WIDTH         = 16
) (
  input logic               clk,
  input logic               rst,
  hazard_ctrl_gen2_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_BFLUSH  = 2'd2
  } state_t;

  localparam int MAX_CYC = (FLUSH_CYCLES > LOAD_STALL_CYCLES) ? FLUSH_CYCLES : LOAD_STALL_CYCLES;
  localparam int RC_W    = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

  localparam logic [RC_W-1:0]      REM_ZERO  = {RC_W{1'b0}};
  localparam logic [RC_W-1:0]      REM_ONE   = RC_W'(1);
  localparam logic [RC_W-1:0]      FL_RELOAD = RC_W'(FLUSH_CYCLES - 1);
  localparam logic [RC_W-1:0]      LD_RELOAD = RC_W'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [RC_W-1:0]      r_rem;
  logic [RC_W-1:0]      w_rem_nxt;
  logic [CNT_WIDTH-1:0] r_stall_count;
  logic [CNT_WIDTH-1:0] r_flush_count;

  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_mem_fwd;
  logic       w_lu;
  logic       w_stall;
  logic       w_flush_if_id;
  logic       w_flush_id_ex;
  logic       w_flush_ex_mem;

  // A producer matches when it writes the same index; r0 is a hard zero when ZERO_REG_EN is set.
  function automatic logic f_match(
    input logic [REG_WIDTH-1:0] src,
    input logic [REG_WIDTH-1:0] dst,
    input logic                 we
  );
    f_match = we && (src == dst) &&
              !((ZERO_REG_EN != 0) && (dst == {REG_WIDTH{1'b0}}));
  endfunction

  // Operand forwarding, store-data forwarding and load-use detection; MEM beats WB.
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (f_match(bus.rsE, bus.WriteRegM, bus.RegWriteM)) begin
      w_fwd_a = 2'b01;
    end else if (f_match(bus.rsE, bus.WriteRegW, bus.RegWriteW)) begin
      w_fwd_a = 2'b10;
    end else begin
      w_fwd_a = 2'b00;
    end
    if (f_match(bus.rtE, bus.WriteRegM, bus.RegWriteM)) begin
      w_fwd_b = 2'b01;
    end else if (f_match(bus.rtE, bus.WriteRegW, bus.RegWriteW)) begin
      w_fwd_b = 2'b10;
    end else begin
      w_fwd_b = 2'b00;
    end
    w_mem_fwd = bus.MemWriteM && bus.MemReadW && f_match(bus.rtM, bus.WriteRegW, bus.RegWriteW);
    w_lu      = bus.MemReadE &&
                ((bus.useRsD && f_match(bus.rsD, bus.WriteRegE, bus.RegWriteE)) ||
                 (bus.useRtD && f_match(bus.rtD, bus.WriteRegE, bus.RegWriteE)));
  end

  // Next state and Mealy stall/flush outputs; priority is branch > load-use > jump.
  always_comb begin
    w_state_nxt    = r_state;
    w_rem_nxt      = r_rem;
    w_stall        = 1'b0;
    w_flush_if_id  = 1'b0;
    w_flush_id_ex  = 1'b0;
    w_flush_ex_mem = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.branch_taken) begin
          w_flush_if_id  = 1'b1;
          w_flush_id_ex  = 1'b1;
          w_flush_ex_mem = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_BFLUSH;
            w_rem_nxt   = FL_RELOAD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = REM_ZERO;
          end
        end else if (w_lu) begin
          // The jump (if any) sits in the stalled ID slot and is re-decoded afterwards.
          w_stall       = 1'b1;
          w_flush_id_ex = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            w_state_nxt = ST_LDSTALL;
            w_rem_nxt   = LD_RELOAD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = REM_ZERO;
          end
        end else if (bus.jump) begin
          w_flush_if_id = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BFLUSH: begin
        w_flush_if_id  = 1'b1;
        w_flush_id_ex  = 1'b1;
        w_flush_ex_mem = 1'b1;
        if (bus.branch_taken) begin
          w_rem_nxt = FL_RELOAD;
        end else if (r_rem <= REM_ONE) begin
          w_state_nxt = ST_IDLE;
          w_rem_nxt   = REM_ZERO;
        end else begin
          w_rem_nxt = r_rem - REM_ONE;
        end
      end
      ST_LDSTALL: begin
        if (bus.branch_taken) begin
          w_flush_if_id  = 1'b1;
          w_flush_id_ex  = 1'b1;
          w_flush_ex_mem = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_BFLUSH;
            w_rem_nxt   = FL_RELOAD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = REM_ZERO;
          end
        end else begin
          w_stall       = 1'b1;
          w_flush_id_ex = 1'b1;
          if (r_rem <= REM_ONE) begin
            w_state_nxt = ST_IDLE;
            w_rem_nxt   = REM_ZERO;
          end else begin
            w_rem_nxt = r_rem - REM_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_rem_nxt   = REM_ZERO;
      end
    endcase
  end

  // FSM state and remaining-cycle register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_rem   <= REM_ZERO;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
    end
  end

  // Saturating stall/flush event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_count <= CNT_ZERO;
      r_flush_count <= CNT_ZERO;
    end else begin
      if (w_stall && (r_stall_count != CNT_MAX)) begin
        r_stall_count <= r_stall_count + CNT_ONE;
      end else begin
        r_stall_count <= r_stall_count;
      end
      if (w_flush_if_id && (r_flush_count != CNT_MAX)) begin
        r_flush_count <= r_flush_count + CNT_ONE;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign bus.fwd_a        = w_fwd_a;
  assign bus.fwd_b        = w_fwd_b;
  assign bus.mem_fwd      = w_mem_fwd;
  assign bus.pc_stall     = w_stall;
  assign bus.if_id_stall  = w_stall;
  assign bus.flush_if_id  = w_flush_if_id;
  assign bus.flush_id_ex  = w_flush_id_ex;
  assign bus.flush_ex_mem = w_flush_ex_mem;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.stall_count  = r_stall_count;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
// Directed bench for hazard_ctrl_gen2: dut_a uses FLUSH=3/LOAD_STALL=2/r0-suppression,
// dut_b uses FLUSH=1/LOAD_STALL=1/no r0-suppression with 2-bit counters.
module tb_hazard_ctrl_gen2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  hazard_ctrl_gen2_if #(.REG_WIDTH(4), .CNT_WIDTH(16)) bus_a ();
  hazard_ctrl_gen2_if #(.REG_WIDTH(4), .CNT_WIDTH(2))  bus_b ();

  hazard_ctrl_gen2 #(
    .REG_WIDTH(4), .FLUSH_CYCLES(3), .LOAD_STALL_CYCLES(2), .ZERO_REG_EN(1), .CNT_WIDTH(16)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));

  hazard_ctrl_gen2 #(
    .REG_WIDTH(4), .FLUSH_CYCLES(1), .LOAD_STALL_CYCLES(1), .ZERO_REG_EN(0), .CNT_WIDTH(2)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  task automatic clear_inputs();
    bus_a.rsD = 4'd0; bus_a.rtD = 4'd0; bus_a.useRsD = 1'b0; bus_a.useRtD = 1'b0;
    bus_a.rsE = 4'd0; bus_a.rtE = 4'd0; bus_a.rtM = 4'd0;
    bus_a.WriteRegE = 4'd0; bus_a.WriteRegM = 4'd0; bus_a.WriteRegW = 4'd0;
    bus_a.RegWriteE = 1'b0; bus_a.RegWriteM = 1'b0; bus_a.RegWriteW = 1'b0;
    bus_a.MemReadE = 1'b0; bus_a.MemReadW = 1'b0; bus_a.MemWriteM = 1'b0;
    bus_a.branch_taken = 1'b0; bus_a.jump = 1'b0;
    bus_b.rsD = 4'd0; bus_b.rtD = 4'd0; bus_b.useRsD = 1'b0; bus_b.useRtD = 1'b0;
    bus_b.rsE = 4'd0; bus_b.rtE = 4'd0; bus_b.rtM = 4'd0;
    bus_b.WriteRegE = 4'd0; bus_b.WriteRegM = 4'd0; bus_b.WriteRegW = 4'd0;
    bus_b.RegWriteE = 1'b0; bus_b.RegWriteM = 1'b0; bus_b.RegWriteW = 1'b0;
    bus_b.MemReadE = 1'b0; bus_b.MemReadW = 1'b0; bus_b.MemWriteM = 1'b0;
    bus_b.branch_taken = 1'b0; bus_b.jump = 1'b0;
  endtask

  // Load-use on dut_a: load writes r5, ID reads r5 through rt.
  task automatic set_lu_a();
    bus_a.MemReadE = 1'b1; bus_a.RegWriteE = 1'b1; bus_a.WriteRegE = 4'd5;
    bus_a.rtD = 4'd5; bus_a.useRtD = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_tests++;
    if ({bus_a.fwd_a, bus_a.fwd_b, bus_a.mem_fwd, bus_a.pc_stall, bus_a.if_id_stall, bus_a.flush_if_id,
         bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.busy, bus_a.stall_count, bus_a.flush_count} !== 43'd0) begin
      n_fail++;
      $display("FAIL reset_a: outputs %b %b %b stall=%0d flush=%0d, want all 0", bus_a.fwd_a, bus_a.fwd_b,
               {bus_a.mem_fwd, bus_a.pc_stall, bus_a.if_id_stall, bus_a.flush_if_id, bus_a.flush_id_ex,
                bus_a.flush_ex_mem, bus_a.busy}, bus_a.stall_count, bus_a.flush_count);
    end
    n_tests++;
    if ({bus_b.fwd_a, bus_b.fwd_b, bus_b.mem_fwd, bus_b.pc_stall, bus_b.if_id_stall, bus_b.flush_if_id,
         bus_b.flush_id_ex, bus_b.flush_ex_mem, bus_b.busy, bus_b.stall_count, bus_b.flush_count} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_b: outputs nonzero, want all 0");
    end
    next_cycle();
  endtask

  task automatic test_forwarding();
    do_reset();
    bus_a.rsE = 4'd3; bus_a.rtE = 4'd3; bus_a.WriteRegM = 4'd3; bus_a.RegWriteM = 1'b1;
    bus_a.WriteRegW = 4'd3; bus_a.RegWriteW = 1'b1;
    #1; n_tests++;
    if (bus_a.fwd_a !== 2'b01 || bus_a.fwd_b !== 2'b01) begin
      n_fail++; $display("FAIL fwd_mem_prio: got a=%b b=%b want 01 01", bus_a.fwd_a, bus_a.fwd_b);
    end
    bus_a.RegWriteM = 1'b0;
    #1; n_tests++;
    if (bus_a.fwd_a !== 2'b10 || bus_a.fwd_b !== 2'b10) begin
      n_fail++; $display("FAIL fwd_wb: got a=%b b=%b want 10 10", bus_a.fwd_a, bus_a.fwd_b);
    end
    bus_a.rtE = 4'd4; bus_a.WriteRegM = 4'd4; bus_a.RegWriteM = 1'b1;
    #1; n_tests++;
    if (bus_a.fwd_a !== 2'b10 || bus_a.fwd_b !== 2'b01) begin
      n_fail++; $display("FAIL fwd_split: got a=%b b=%b want 10 01", bus_a.fwd_a, bus_a.fwd_b);
    end
    bus_a.rtE = 4'd9;
    #1; n_tests++;
    if (bus_a.fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_none: got b=%b want 00", bus_a.fwd_b);
    end
    bus_a.rsE = 4'd0; bus_a.rtE = 4'd0; bus_a.WriteRegM = 4'd0; bus_a.WriteRegW = 4'd0;
    bus_b.rsE = 4'd0; bus_b.rtE = 4'd0; bus_b.WriteRegM = 4'd0; bus_b.WriteRegW = 4'd0;
    bus_b.RegWriteM = 1'b1; bus_b.RegWriteW = 1'b1;
    #1; n_tests++;
    if (bus_a.fwd_a !== 2'b00 || bus_a.fwd_b !== 2'b00) begin
      n_fail++; $display("FAIL fwd_r0_suppress: got a=%b b=%b want 00 00", bus_a.fwd_a, bus_a.fwd_b);
    end
    n_tests++;
    if (bus_b.fwd_a !== 2'b01 || bus_b.fwd_b !== 2'b01) begin
      n_fail++; $display("FAIL fwd_r0_allowed: got a=%b b=%b want 01 01", bus_b.fwd_a, bus_b.fwd_b);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    logic [3:0] exp_st;
    do_reset();
    exp_st = 4'b0011;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_lu_a(); else clear_inputs();
      @(negedge clk); n_tests++;
      if ({bus_a.pc_stall, bus_a.if_id_stall, bus_a.flush_id_ex, bus_a.flush_if_id, bus_a.flush_ex_mem}
          !== {{3{exp_st[c]}}, 2'b00}) begin
        n_fail++;
        $display("FAIL lu_stall cyc%0d: got %b want %b", c, {bus_a.pc_stall, bus_a.if_id_stall,
                 bus_a.flush_id_ex, bus_a.flush_if_id, bus_a.flush_ex_mem}, {{3{exp_st[c]}}, 2'b00});
      end
      next_cycle();
    end
    n_tests++;
    if (bus_a.stall_count !== 16'd2) begin
      n_fail++; $display("FAIL lu_stall_count: got %0d want 2", bus_a.stall_count);
    end
    set_lu_a(); bus_a.useRtD = 1'b0;
    #1; n_tests++;
    if (bus_a.pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_unused_rt: got pc_stall=%b want 0", bus_a.pc_stall);
    end
    bus_a.rsD = 4'd5; bus_a.useRsD = 1'b1;
    #1; n_tests++;
    if (bus_a.pc_stall !== 1'b1) begin
      n_fail++; $display("FAIL lu_rs: got pc_stall=%b want 1", bus_a.pc_stall);
    end
    bus_a.rsD = 4'd0; bus_a.WriteRegE = 4'd0;
    #1; n_tests++;
    if (bus_a.pc_stall !== 1'b0) begin
      n_fail++; $display("FAIL lu_r0: got pc_stall=%b want 0", bus_a.pc_stall);
    end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_branch();
    logic [5:0] exp_fl;
    logic [5:0] exp_bz;
    do_reset();
    exp_fl = 6'b000111;
    exp_bz = 6'b000110;
    for (int c = 0; c < 5; c++) begin
      bus_a.branch_taken = (c == 0);
      @(negedge clk); n_tests++;
      if ({bus_a.flush_if_id, bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.busy, bus_a.pc_stall}
          !== {{3{exp_fl[c]}}, exp_bz[c], 1'b0}) begin
        n_fail++;
        $display("FAIL branch1 cyc%0d: got fl=%b%b%b busy=%b stall=%b want %b busy=%b", c, bus_a.flush_if_id,
                 bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.busy, bus_a.pc_stall, {3{exp_fl[c]}}, exp_bz[c]);
      end
      next_cycle();
    end
    n_tests++;
    if (bus_a.flush_count !== 16'd3) begin
      n_fail++; $display("FAIL branch1_flush_count: got %0d want 3", bus_a.flush_count);
    end
    do_reset();
    exp_fl = 6'b001111;
    exp_bz = 6'b001110;
    for (int c = 0; c < 6; c++) begin
      bus_a.branch_taken = (c < 2);
      @(negedge clk); n_tests++;
      if ({bus_a.flush_if_id, bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.busy}
          !== {{3{exp_fl[c]}}, exp_bz[c]}) begin
        n_fail++;
        $display("FAIL branch2 cyc%0d: got fl=%b%b%b busy=%b want %b busy=%b", c, bus_a.flush_if_id,
                 bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.busy, {3{exp_fl[c]}}, exp_bz[c]);
      end
      next_cycle();
    end
    n_tests++;
    if (bus_a.flush_count !== 16'd4) begin
      n_fail++; $display("FAIL branch2_flush_count: got %0d want 4", bus_a.flush_count);
    end
  endtask

  task automatic test_jump();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      bus_a.jump = (c == 0);
      @(negedge clk); n_tests++;
      if ({bus_a.flush_if_id, bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.pc_stall, bus_a.busy}
          !== {(c == 0), 4'b0000}) begin
        n_fail++;
        $display("FAIL jump cyc%0d: got %b want %b", c, {bus_a.flush_if_id, bus_a.flush_id_ex,
                 bus_a.flush_ex_mem, bus_a.pc_stall, bus_a.busy}, {(c == 0), 4'b0000});
      end
      next_cycle();
    end
    n_tests++;
    if (bus_a.flush_count !== 16'd1) begin
      n_fail++; $display("FAIL jump_flush_count: got %0d want 1", bus_a.flush_count);
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp_fl;
    logic [4:0] exp_st;
    do_reset();
    exp_fl = 5'b00111;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        set_lu_a(); bus_a.jump = 1'b1;
      end else begin
        clear_inputs();
      end
      bus_a.branch_taken = (c == 0);
      @(negedge clk); n_tests++;
      if ({bus_a.flush_if_id, bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.pc_stall, bus_a.if_id_stall}
          !== {{3{exp_fl[c]}}, 2'b00}) begin
        n_fail++;
        $display("FAIL all_events cyc%0d: got %b want %b", c, {bus_a.flush_if_id, bus_a.flush_id_ex,
                 bus_a.flush_ex_mem, bus_a.pc_stall, bus_a.if_id_stall}, {{3{exp_fl[c]}}, 2'b00});
      end
      next_cycle();
    end
    do_reset();
    set_lu_a(); bus_a.jump = 1'b1;
    @(negedge clk); n_tests++;
    if ({bus_a.pc_stall, bus_a.if_id_stall, bus_a.flush_id_ex, bus_a.flush_if_id, bus_a.flush_ex_mem}
        !== 5'b11100) begin
      n_fail++;
      $display("FAIL lu_jump: got %b want 11100", {bus_a.pc_stall, bus_a.if_id_stall, bus_a.flush_id_ex,
               bus_a.flush_if_id, bus_a.flush_ex_mem});
    end
    next_cycle();
    do_reset();
    exp_st = 5'b00001;
    exp_fl = 5'b01110;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) set_lu_a(); else clear_inputs();
      bus_a.branch_taken = (c == 1);
      @(negedge clk); n_tests++;
      if ({bus_a.pc_stall, bus_a.flush_if_id, bus_a.flush_id_ex, bus_a.flush_ex_mem}
          !== {exp_st[c], exp_fl[c], exp_st[c] | exp_fl[c], exp_fl[c]}) begin
        n_fail++;
        $display("FAIL branch_in_ldstall cyc%0d: got %b want %b", c, {bus_a.pc_stall, bus_a.flush_if_id,
                 bus_a.flush_id_ex, bus_a.flush_ex_mem}, {exp_st[c], exp_fl[c], exp_st[c] | exp_fl[c], exp_fl[c]});
      end
      next_cycle();
    end
  endtask

  task automatic test_store_fwd();
    do_reset();
    bus_a.MemWriteM = 1'b1; bus_a.rtM = 4'd7; bus_a.MemReadW = 1'b1;
    bus_a.RegWriteW = 1'b1; bus_a.WriteRegW = 4'd7;
    #1; n_tests++;
    if (bus_a.mem_fwd !== 1'b1) begin
      n_fail++; $display("FAIL mem_fwd_hit: got %b want 1", bus_a.mem_fwd);
    end
    bus_a.rtM = 4'd6;
    #1; n_tests++;
    if (bus_a.mem_fwd !== 1'b0) begin
      n_fail++; $display("FAIL mem_fwd_miss: got %b want 0", bus_a.mem_fwd);
    end
    bus_a.rtM = 4'd7; bus_a.MemReadW = 1'b0;
    #1; n_tests++;
    if (bus_a.mem_fwd !== 1'b0) begin
      n_fail++; $display("FAIL mem_fwd_noload: got %b want 0", bus_a.mem_fwd);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_a.branch_taken = 1'b1;
    next_cycle();
    bus_a.branch_taken = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk); n_tests++;
    if (bus_a.busy !== 1'b1 || bus_a.flush_ex_mem !== 1'b1) begin
      n_fail++; $display("FAIL pre_rst_bflush: got busy=%b flush=%b want 1 1", bus_a.busy, bus_a.flush_ex_mem);
    end
    next_cycle();
    rst = 1'b0;
    @(negedge clk); n_tests++;
    if ({bus_a.pc_stall, bus_a.if_id_stall, bus_a.flush_if_id, bus_a.flush_id_ex, bus_a.flush_ex_mem,
         bus_a.busy, bus_a.stall_count, bus_a.flush_count} !== 38'd0) begin
      n_fail++;
      $display("FAIL rst_mid_bflush: got %b cnt=%0d/%0d want all 0", {bus_a.pc_stall, bus_a.if_id_stall,
               bus_a.flush_if_id, bus_a.flush_id_ex, bus_a.flush_ex_mem, bus_a.busy},
               bus_a.stall_count, bus_a.flush_count);
    end
    next_cycle();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 5) begin
        bus_b.MemReadE = 1'b1; bus_b.RegWriteE = 1'b1; bus_b.WriteRegE = 4'd5;
        bus_b.rtD = 4'd5; bus_b.useRtD = 1'b1;
      end else begin
        clear_inputs();
      end
      exp_cnt = (c > 3) ? 2'd3 : c[1:0];
      @(negedge clk); n_tests++;
      if (bus_b.stall_count !== exp_cnt || bus_b.pc_stall !== (c < 5) || bus_b.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_sat cyc%0d: got cnt=%0d stall=%b busy=%b want cnt=%0d stall=%b busy=0", c,
                 bus_b.stall_count, bus_b.pc_stall, bus_b.busy, exp_cnt, (c < 5));
      end
      next_cycle();
    end
    n_tests++;
    if (bus_b.stall_count !== 2'd3) begin
      n_fail++; $display("FAIL stall_sat_hold: got %0d want 3", bus_b.stall_count);
    end
    do_reset();
    for (int c = 0; c < 5; c++) begin
      bus_b.branch_taken = 1'b1;
      @(negedge clk); n_tests++;
      if (bus_b.flush_ex_mem !== 1'b1 || bus_b.busy !== 1'b0) begin
        n_fail++; $display("FAIL flush1 cyc%0d: got flush=%b busy=%b want 1 0", c, bus_b.flush_ex_mem, bus_b.busy);
      end
      next_cycle();
    end
    clear_inputs();
    @(negedge clk); n_tests++;
    if (bus_b.flush_count !== 2'd3 || bus_b.flush_if_id !== 1'b0) begin
      n_fail++; $display("FAIL flush_sat: got cnt=%0d flush=%b want 3 0", bus_b.flush_count, bus_b.flush_if_id);
    end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_jump();
    test_simultaneous();
    test_store_fwd();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
